demux_1to4_reg: RTL and testbench

- Registered 1-to-4 demultiplexer: routes data word A to one of four output buses W/X/Y/Z, selected by SEL.
- Sits between a single producer and four consumer lanes. Gives a clean, registered, one-hot lane output with a per-lane valid strobe.
- Unselected lanes are driven to zero.

---
 rtl/demux_1to4_reg.sv | 84 ++++++++
 tb/tb_demux_1to4_reg.sv | 131 +++++++++++++
 2 files changed

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demux: routes A to lane W/X/Y/Z by SEL, with a one-hot per-lane valid strobe.
// Build option DEMUX_HOLD_UNSEL_EN: unselected lanes keep their data on a capture instead of clearing.

module demux_1to4_reg_lane #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             hit,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] q,
    output logic             vld
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            vld <= 1'b0;
        end else if (en) begin
            vld <= hit;
`ifdef DEMUX_HOLD_UNSEL_EN
            if (hit)
                q <= a;
`else
            q <= hit ? a : '0;
`endif
        end
    end

endmodule

module demux_1to4_reg #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [1:0]       SEL,
    input  logic             EN,
    output logic [WIDTH-1:0] W,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Z,
    output logic [3:0]       LANE_VLD
);

    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0]            hit;
    logic [NUM_LANES-1:0][WIDTH-1:0] lane_q;
    logic [NUM_LANES-1:0]            lane_vld;

    // Unknown SEL falls to default: every lane clears and no valid is raised.
    always_comb begin
        hit = '0;
        case (SEL)
            2'b00:   hit = 4'b0001;
            2'b01:   hit = 4'b0010;
            2'b10:   hit = 4'b0100;
            2'b11:   hit = 4'b1000;
            default: hit = 4'b0000;
        endcase
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        demux_1to4_reg_lane #(.WIDTH(WIDTH)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (EN),
            .hit   (hit[g]),
            .a     (A),
            .q     (lane_q[g]),
            .vld   (lane_vld[g])
        );
    end

    assign W        = lane_q[0];
    assign X        = lane_q[1];
    assign Y        = lane_q[2];
    assign Z        = lane_q[3];
    assign LANE_VLD = lane_vld;

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Directed bench for demux_1to4_reg; observed word is {LANE_VLD, W, X, Y, Z}.
// Expectations follow DEMUX_HOLD_UNSEL_EN when the bench is built with it.

module tb_demux_1to4_reg;

    localparam int WIDTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] A;
    logic [1:0]       SEL;
    logic             EN;
    logic [WIDTH-1:0] W, X, Y, Z;
    logic [3:0]       LANE_VLD;

    int total = 0;
    int bad   = 0;

    demux_1to4_reg #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .SEL      (SEL),
        .EN       (EN),
        .W        (W),
        .X        (X),
        .Y        (Y),
        .Z        (Z),
        .LANE_VLD (LANE_VLD)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] exp);
        logic [11:0] obs;
        obs = {LANE_VLD, W, X, Y, Z};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; A = 2'b11; SEL = 2'b10; EN = 1'b1;
        #1;
        chk("reset_async_t0", 12'b0000_00_00_00_00);
        tick(); tick(); tick();
        chk("reset_held_edges", 12'b0000_00_00_00_00);

        rst_n = 1'b1; A = 2'b00; SEL = 2'b00;
        tick();
        chk("lane_w_zero", 12'b0001_00_00_00_00);

        A = 2'b01; SEL = 2'b01;
        tick();
        chk("lane_x", 12'b0010_00_01_00_00);

        A = 2'b01; SEL = 2'b10;
        tick();
`ifdef DEMUX_HOLD_UNSEL_EN
        chk("lane_y", 12'b0100_00_01_01_00);
`else
        chk("lane_y", 12'b0100_00_00_01_00);
`endif

        A = 2'b11; SEL = 2'b11;
        tick();
`ifdef DEMUX_HOLD_UNSEL_EN
        chk("lane_z", 12'b1000_00_01_01_11);
`else
        chk("lane_z", 12'b1000_00_00_00_11);
`endif

        EN = 1'b0; A = 2'b10; SEL = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
`ifdef DEMUX_HOLD_UNSEL_EN
            chk("en_low_hold", 12'b1000_00_01_01_11);
`else
            chk("en_low_hold", 12'b1000_00_00_00_11);
`endif
        end

        EN = 1'b1;
        tick();
`ifdef DEMUX_HOLD_UNSEL_EN
        chk("en_rise_w", 12'b0001_10_01_01_11);
`else
        chk("en_rise_w", 12'b0001_10_00_00_00);
`endif

        A = 2'b11; SEL = 2'b10;
        tick();
`ifdef DEMUX_HOLD_UNSEL_EN
        chk("sel_switch_y", 12'b0100_10_01_11_11);
`else
        chk("sel_switch_y", 12'b0100_00_00_11_00);
`endif

        A = 2'b10; SEL = 2'b01;
        tick();
`ifdef DEMUX_HOLD_UNSEL_EN
        chk("sel_switch_x", 12'b0010_10_10_11_11);
`else
        chk("sel_switch_x", 12'b0010_00_10_00_00);
`endif

        // Mid-cycle reset: outputs must clear well before the next rising edge.
        A = 2'b01; SEL = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_cycle", 12'b0000_00_00_00_00);
        tick();
        chk("reset_discards_capture", 12'b0000_00_00_00_00);

        rst_n = 1'b1;
        tick();
        chk("post_reset_z", 12'b1000_00_00_00_01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
